// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel coordinates, active-video flag, sync pins and a
// once-per-frame strobe at the start of vertical blanking. Defaults are 640x480@60.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       next_frame,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must be in 1..1024");
    end
  endgenerate

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  // Region bounds widened to 11 bits so a 1024-wide region still compares correctly.
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] H_HS0 = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] V_VS0 = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  x_nxt;
  logic [9:0]  y_nxt;
  logic        line_end;
  logic        frame_end;
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        act_nxt;
  logic        hs_on;
  logic        vs_on;
  logic        nf_nxt;

  always_comb begin
    x_nxt     = x + 10'd1;
    y_nxt     = y;
    line_end  = (x == H_LAST);
    frame_end = 1'b0;
    if (line_end) begin
      x_nxt = 10'd0;
      if (y == V_LAST) begin
        y_nxt     = 10'd0;
        frame_end = 1'b1;
      end else begin
        y_nxt = y + 10'd1;
      end
    end
  end

  // Sync/active are derived from the coordinates being loaded so they line up with x/y.
  always_comb begin
    x_ext   = {1'b0, x_nxt};
    y_ext   = {1'b0, y_nxt};
    act_nxt = (x_ext < H_ACT) && (y_ext < V_ACT);
    hs_on   = (x_ext >= H_HS0) && (x_ext < H_HS1);
    vs_on   = (y_ext >= V_VS0) && (y_ext < V_VS1);
    nf_nxt  = line_end && (y_ext == V_ACT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x          <= 10'd0;
      y          <= 10'd0;
      frame_cnt  <= 8'd0;
      next_frame <= 1'b0;
      active     <= 1'b1;
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
    end else begin
      next_frame <= 1'b0;
      if (pix_ce) begin
        x          <= x_nxt;
        y          <= y_nxt;
        active     <= act_nxt;
        hsync      <= hs_on ? HS_POL : ~HS_POL;
        vsync      <= vs_on ? VS_POL : ~VS_POL;
        next_frame <= nf_nxt;
        if (frame_end) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a short-frame variant with
// default horizontal timing, and a tiny active-high-hsync variant.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n_v [3];
  logic ce_v    [3];
  logic [9:0] x_o [3];
  logic [9:0] y_o [3];
  logic act_o [3];
  logic hs_o  [3];
  logic vs_o  [3];
  logic nf_o  [3];
  logic [7:0] fc_o [3];

  // Hand-derived timing per instance: def / mid (12-line frame) / sml.
  localparam int HA   [3] = '{640, 640, 8};
  localparam int HS0  [3] = '{656, 656, 10};
  localparam int HS1  [3] = '{752, 752, 12};
  localparam int HTOT [3] = '{800, 800, 14};
  localparam int VA   [3] = '{480, 12, 4};
  localparam int VS0  [3] = '{490, 14, 5};
  localparam int VS1  [3] = '{492, 16, 6};
  localparam int VTOT [3] = '{525, 19, 7};
  localparam int HPOL [3] = '{0, 0, 1};
  localparam int VPOL [3] = '{0, 0, 0};

  string tnm [3] = '{"def", "mid", "sml"};

  int n_cmp = 0;
  int n_mis = 0;

  int ex [3], ey [3], efc [3], enf [3];
  int cec [3], np [3], pfirst [3], plast [3], pgap [3];

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n_v[0]), .pix_ce(ce_v[0]),
    .x(x_o[0]), .y(y_o[0]), .active(act_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]),
    .next_frame(nf_o[0]), .frame_cnt(fc_o[0])
  );

  vga_timing_gen #(.V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_mid (
    .clk(clk), .rst_n(rst_n_v[1]), .pix_ce(ce_v[1]),
    .x(x_o[1]), .y(y_o[1]), .active(act_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]),
    .next_frame(nf_o[1]), .frame_cnt(fc_o[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)
  ) u_sml (
    .clk(clk), .rst_n(rst_n_v[2]), .pix_ce(ce_v[2]),
    .x(x_o[2]), .y(y_o[2]), .active(act_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]),
    .next_frame(nf_o[2]), .frame_cnt(fc_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clk edge; inputs were set by the caller before the edge, outputs sampled 1ns after.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n_v[k]) begin
        ex[k] = 0; ey[k] = 0; efc[k] = 0; enf[k] = 0;
        cec[k] = 0; np[k] = 0; pfirst[k] = -1; plast[k] = 0; pgap[k] = -1;
      end else if (ce_v[k]) begin
        enf[k] = (ex[k] == HTOT[k] - 1 && ey[k] == VA[k] - 1) ? 1 : 0;
        if (ex[k] == HTOT[k] - 1) begin
          ex[k] = 0;
          if (ey[k] == VTOT[k] - 1) begin
            ey[k]  = 0;
            efc[k] = (efc[k] + 1) % 256;
          end else begin
            ey[k]++;
          end
        end else begin
          ex[k]++;
        end
        cec[k]++;
      end else begin
        enf[k] = 0;
      end
      chk({tnm[k], ".x"}, int'(x_o[k]), ex[k]);
      chk({tnm[k], ".y"}, int'(y_o[k]), ey[k]);
      chk({tnm[k], ".active"}, int'(act_o[k]), (ex[k] < HA[k] && ey[k] < VA[k]) ? 1 : 0);
      chk({tnm[k], ".hsync"}, int'(hs_o[k]),
          (ex[k] >= HS0[k] && ex[k] < HS1[k]) ? HPOL[k] : 1 - HPOL[k]);
      chk({tnm[k], ".vsync"}, int'(vs_o[k]),
          (ey[k] >= VS0[k] && ey[k] < VS1[k]) ? VPOL[k] : 1 - VPOL[k]);
      chk({tnm[k], ".next_frame"}, int'(nf_o[k]), enf[k]);
      chk({tnm[k], ".frame_cnt"}, int'(fc_o[k]), efc[k]);
      if (nf_o[k] && rst_n_v[k]) begin
        np[k]++;
        if (np[k] == 1) pfirst[k] = cec[k];
        else pgap[k] = cec[k] - plast[k];
        plast[k] = cec[k];
      end
    end
  endtask

  bit pat_ce [7] = '{1, 0, 0, 1, 0, 0, 1};
  int pat_x  [7] = '{799, 799, 799, 0, 0, 0, 1};
  int pat_y  [7] = '{11, 11, 11, 12, 12, 12, 12};
  int pat_nf [7] = '{0, 0, 0, 1, 0, 0, 0};

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n_v[k] = 1'b0;
      ce_v[k]    = 1'b1;
    end
    repeat (3) tick();
    chk("def.rst_x", int'(x_o[0]), 0);
    chk("def.rst_hsync", int'(hs_o[0]), 1);
    chk("def.rst_vsync", int'(vs_o[0]), 1);
    chk("def.rst_active", int'(act_o[0]), 1);
    chk("sml.rst_hsync", int'(hs_o[2]), 0);

    // Default timing: two lines and a bit, then reset mid-line.
    rst_n_v[0] = 1'b1;
    repeat (1900) tick();
    chk("def.pos_x", int'(x_o[0]), 300);
    chk("def.pos_y", int'(y_o[0]), 2);
    rst_n_v[0] = 1'b0;
    tick();
    chk("def.midreset_x", int'(x_o[0]), 0);
    chk("def.midreset_y", int'(y_o[0]), 0);
    chk("def.midreset_nf", int'(nf_o[0]), 0);

    // Short frame: 800x19 total, 12 active lines.
    rst_n_v[1] = 1'b1;
    repeat (30500) tick();
    chk("mid.pulses", np[1], 2);
    chk("mid.first_pulse", pfirst[1], 9600);
    chk("mid.pulse_gap", pgap[1], 15200);
    chk("mid.frames", int'(fc_o[1]), 2);

    // pix_ce gating around the last active pixel.
    repeat (9498) tick();
    chk("mid.pre_x", int'(x_o[1]), 798);
    chk("mid.pre_y", int'(y_o[1]), 11);
    for (int i = 0; i < 7; i++) begin
      ce_v[1] = pat_ce[i];
      tick();
      chk("mid.gate_x", int'(x_o[1]), pat_x[i]);
      chk("mid.gate_y", int'(y_o[1]), pat_y[i]);
      chk("mid.gate_nf", int'(nf_o[1]), pat_nf[i]);
    end
    chk("mid.gate_pulses", np[1], 3);
    ce_v[1] = 1'b1;

    // Mid-frame reset restarts pulse timing.
    rst_n_v[1] = 1'b0;
    tick();
    rst_n_v[1] = 1'b1;
    repeat (9650) tick();
    chk("mid.rst_pulses", np[1], 1);
    chk("mid.rst_first_pulse", pfirst[1], 9600);
    rst_n_v[1] = 1'b0;

    // Tiny 14x7 raster with active-high hsync.
    rst_n_v[2] = 1'b1;
    repeat (300) tick();
    chk("sml.pulses", np[2], 3);
    chk("sml.first_pulse", pfirst[2], 56);
    chk("sml.pulse_gap", pgap[2], 98);
    chk("sml.frames", int'(fc_o[2]), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing source for the pattern generators. Produces the pixel coordinates (x, y), the active-video flag, the once-per-frame next_frame strobe, and the hsync/vsync pins that every pattern module consumes. Defaults give 640x480@60 timing. Advances one pixel per clk cycle on which pix_ce is high.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hsync (0 = active-low)
VS_POL, 0, asserted level of vsync (0 = active-low)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
pix_ce  input  1  pixel-advance enable; tie high when clk is the pixel clock
x  output  10  horizontal counter, 0..H_TOTAL-1
y  output  10  vertical counter, 0..V_TOTAL-1
active  output  1  high when x < H_ACTIVE and y < V_ACTIVE
hsync  output  1  horizontal sync at HS_POL level during the sync region
vsync  output  1  vertical sync at VS_POL level during the sync region
next_frame  output  1  single-clk strobe at start of vertical blanking
frame_cnt  output  8  frame counter, wraps 255->0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both totals must be at most 1024; this is an elaboration-time check.
- Reset: on a clk edge with rst_n=0, x=0, y=0, frame_cnt=0, next_frame=0, active=1, hsync=!HS_POL, vsync=!VS_POL. Reset dominates pix_ce and takes effect mid-line or mid-frame.
- All outputs are registered. hsync, vsync and active are computed from the next counter values, so they are cycle-aligned with x and y. The following invariants hold on every cycle:
  - active == (x<H_ACTIVE && y<V_ACTIVE)
  - hsync == HS_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751)
  - vsync == VS_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491)
- Counter rules on an edge with pix_ce=1:
  - x<H_TOTAL-1: x+1.
  - x==H_TOTAL-1: x=0. In the same edge, y increments, or wraps to 0 if y==V_TOTAL-1.
  - Wrap to (0,0): frame_cnt increments, mod 256, on that same edge.
- Edge with pix_ce=0: x, y, frame_cnt, hsync, vsync and active hold; next_frame=0.
- next_frame: high for exactly one clk, on the edge where the counters move to (x=0, y=V_ACTIVE). Low on every other cycle, including while pix_ce=0 holds the counters at (0,V_ACTIVE). Exactly one pulse per V_TOTAL*H_TOTAL pix_ce cycles. Consumers update per-frame state during blanking.
- No pulse is generated by reset itself. The first next_frame after reset comes V_ACTIVE*H_TOTAL pix_ce cycles later (384000 by default).

Test Plan:
- Reset, then hold rst_n=0 for 3 clks -> x=0, y=0, active=1, hsync=1, vsync=1, next_frame=0, frame_cnt=0.
- pix_ce=1 continuous from reset, checking all invariants every cycle -> hsync falls entering x=656 and rises entering x=752; active falls entering x=640; x wraps 799->0 while y goes 0->1.
- Run 2 full frames -> next_frame pulses exactly twice, each time coinciding with x=0, y=480. Pulses are 420000 clks apart. vsync is low only on lines 490-491. frame_cnt goes 0->1->2 on each wrap to (0,0).
- pix_ce toggling 1,0,0,1 around x=799, y=479 -> counters hold during the zero cycles. next_frame is a single one-clk pulse on the advancing edge and stays low on the held cycles.
- Assert rst_n=0 for one clk at x=300, y=200 -> next cycle shows (0,0) and reset values; pulse timing restarts, with the first next_frame 384000 pix_ce cycles later.
- Override parameters to H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1 -> H_TOTAL=14, V_TOTAL=7. hsync is high only at x=10..11, and next_frame repeats every 98 clks.
